seq_stage_ctrl: RTL and testbench

//   Multi-cycle sequencer for the Y86-64 SEQ core. Owns the architectural PC

---
 rtl/seq_stage_ctrl_if.sv | 47 ++++
 rtl/seq_stage_ctrl.sv | 182 ++++++++++++++++++
 tb/tb_seq_stage_ctrl.sv | 277 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/seq_stage_ctrl_if.sv
// Sequencer <-> datapath bundle for the Y86-64 SEQ core.
// Optional RETIRE_CNT_EN adds the retired instruction counter.
interface seq_stage_ctrl_if #(
  parameter int PC_WIDTH = 64
);
  logic                run;
  logic [3:0]          icode;
  logic                cnd;
  logic [PC_WIDTH-1:0] valC;
  logic [PC_WIDTH-1:0] valM;
  logic [PC_WIDTH-1:0] valP;
  logic                imem_error;
  logic                dmem_ready;
  logic                dmem_error;
  logic [PC_WIDTH-1:0] pc;
  logic [5:0]          stage;
  logic [2:0]          stat;
  logic                retire;
  logic                halted;
`ifdef RETIRE_CNT_EN
  logic [31:0]         retired_cnt;
`endif

  modport master (
    input  run, icode, cnd,
    input  valC, valM, valP,
    input  imem_error,
    input  dmem_ready, dmem_error,
    output pc, stage, stat,
    output retire, halted
`ifdef RETIRE_CNT_EN
    , output retired_cnt
`endif
  );

  modport slave (
    output run, icode, cnd,
    output valC, valM, valP,
    output imem_error,
    output dmem_ready, dmem_error,
    input  pc, stage, stat,
    input  retire, halted
`ifdef RETIRE_CNT_EN
    , input retired_cnt
`endif
  );
endinterface

// File: rtl/seq_stage_ctrl.sv
// Multi-cycle stage sequencer and PC owner for the Y86-64 SEQ core.
// Define RETIRE_CNT_EN to add the 32-bit retired instruction counter.
module seq_stage_ctrl #(
  parameter int                   PC_WIDTH     = 64,
  parameter logic [PC_WIDTH-1:0]  RESET_PC     = '0,
  parameter int                   MEM_WAIT_MAX = 15
) (
  input  logic             clk,
  input  logic             rst,
  seq_stage_ctrl_if.master bus
);

  localparam int WW =
    (MEM_WAIT_MAX < 2) ? 1 :
    $clog2(MEM_WAIT_MAX + 1);

  localparam logic [2:0] ST_AOK = 3'd1;
  localparam logic [2:0] ST_HLT = 3'd2;
  localparam logic [2:0] ST_ADR = 3'd3;
  localparam logic [2:0] ST_INS = 3'd4;

  typedef enum logic [2:0] {
    S_FET,
    S_DEC,
    S_EXE,
    S_MEM,
    S_WB,
    S_PCU,
    S_HLT
  } state_t;

  state_t              state_q, state_d;
  logic [PC_WIDTH-1:0] pc_q, pc_d;
  logic [5:0]          stage_q, stage_d;
  logic [2:0]          stat_q, stat_d;
  logic                retire_q, retire_d;
  logic                halted_q, halted_d;
  logic [WW-1:0]       wait_q, wait_d;
  logic [PC_WIDTH-1:0] new_pc;
  logic                mem_op;
`ifdef RETIRE_CNT_EN
  logic [31:0]         cnt_q, cnt_d;
`endif

  function automatic logic is_mem(
    input logic [3:0] ic
  );
    return ic inside {
      4'h4, 4'h5, 4'h8,
      4'h9, 4'hA, 4'hB
    };
  endfunction

  assign mem_op = is_mem(bus.icode);

  // Next PC from the instruction class.
  always_comb begin
    new_pc = bus.valP;
    unique case (bus.icode)
      4'h7:    new_pc = bus.cnd ? bus.valC : bus.valP;
      4'h8:    new_pc = bus.valC;
      4'h9:    new_pc = bus.valM;
      default: new_pc = bus.valP;
    endcase
  end

  // Stage transitions, fault capture and registered-output next values.
  always_comb begin
    state_d  = state_q;
    pc_d     = pc_q;
    stat_d   = stat_q;
    wait_d   = wait_q;
    retire_d = 1'b0;
    halted_d = halted_q;
`ifdef RETIRE_CNT_EN
    cnt_d    = cnt_q;
`endif
    unique case (state_q)
      S_FET: begin
        if (bus.run) begin
          if (bus.imem_error) begin
            stat_d = ST_ADR;
            state_d = S_HLT;
          end else if (bus.icode > 4'hB) begin
            stat_d = ST_INS;
            state_d = S_HLT;
          end else if (bus.icode == 4'h0) begin
            stat_d = ST_HLT;
            state_d = S_HLT;
          end else begin
            state_d = S_DEC;
          end
        end
      end
      S_DEC: state_d = S_EXE;
      S_EXE: begin
        state_d = S_MEM;
        wait_d  = '0;
      end
      S_MEM: begin
        if (!mem_op) begin
          state_d = S_WB;
        end else if (bus.dmem_ready) begin
          if (bus.dmem_error) begin
            stat_d  = ST_ADR;
            state_d = S_HLT;
          end else begin
            state_d = S_WB;
          end
        end else if (wait_q ==
                     WW'(MEM_WAIT_MAX - 1)) begin
          stat_d  = ST_ADR;
          state_d = S_HLT;
        end else begin
          wait_d = wait_q + 1'b1;
        end
      end
      S_WB: begin
        state_d  = S_PCU;
        pc_d     = new_pc;
        retire_d = 1'b1;
`ifdef RETIRE_CNT_EN
        cnt_d    = cnt_q + 32'd1;
`endif
      end
      S_PCU: state_d = S_FET;
      S_HLT: state_d = S_HLT;
      default: state_d = S_FET;
    endcase

    if (state_d == S_HLT) halted_d = 1'b1;

    stage_d = 6'b000000;
    unique case (state_d)
      S_FET:   stage_d = 6'b000001;
      S_DEC:   stage_d = 6'b000010;
      S_EXE:   stage_d = 6'b000100;
      S_MEM:   stage_d = 6'b001000;
      S_WB:    stage_d = 6'b010000;
      S_PCU:   stage_d = 6'b100000;
      default: stage_d = 6'b000000;
    endcase
  end

  // State and registered outputs, synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= S_FET;
      pc_q     <= RESET_PC;
      stage_q  <= 6'b000001;
      stat_q   <= ST_AOK;
      retire_q <= 1'b0;
      halted_q <= 1'b0;
      wait_q   <= '0;
    end else begin
      state_q  <= state_d;
      pc_q     <= pc_d;
      stage_q  <= stage_d;
      stat_q   <= stat_d;
      retire_q <= retire_d;
      halted_q <= halted_d;
      wait_q   <= wait_d;
    end
  end

`ifdef RETIRE_CNT_EN
  // Retired instruction counter, wraps naturally.
  always_ff @(posedge clk) begin
    if (rst) cnt_q <= '0;
    else     cnt_q <= cnt_d;
  end

  assign bus.retired_cnt = cnt_q;
`endif

  assign bus.pc     = pc_q;
  assign bus.stage  = stage_q;
  assign bus.stat   = stat_q;
  assign bus.retire = retire_q;
  assign bus.halted = halted_q;

endmodule

// File: tb/tb_seq_stage_ctrl.sv
// Directed bench for seq_stage_ctrl with a per-instruction model.
// Build with RETIRE_CNT_EN to also check retired_cnt.
module tb_seq_stage_ctrl;

  localparam int          PW  = 64;
  localparam logic [63:0] RPC = 64'h100;
  localparam int          MWM = 15;

  logic clk;
  logic rst;

  seq_stage_ctrl_if #(.PC_WIDTH(PW)) bus ();

  seq_stage_ctrl #(
    .PC_WIDTH(PW),
    .RESET_PC(RPC),
    .MEM_WAIT_MAX(MWM)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;
  bit chk_en  = 1'b0;

  logic [5:0]  exp_stage;
  logic [63:0] exp_pc;
  logic [2:0]  exp_stat;
  logic        exp_retire;
  logic        exp_halted;
  logic [31:0] exp_cnt;

  task automatic cmp(
    input string       nm,
    input logic [63:0] act,
    input logic [63:0] want
  );
    n_tests++;
    if (act !== want) begin
      n_fail++;
      $display("FAIL %s: got %0h want %0h @%0t",
               nm, act, want, $time);
    end
  endtask

  // Check every cycle against the model.
  always @(negedge clk) begin
    if (chk_en) begin
      cmp("stage",  64'(bus.stage),  64'(exp_stage));
      cmp("pc",     bus.pc,          exp_pc);
      cmp("stat",   64'(bus.stat),   64'(exp_stat));
      cmp("retire", 64'(bus.retire), 64'(exp_retire));
      cmp("halted", 64'(bus.halted), 64'(exp_halted));
`ifdef RETIRE_CNT_EN
      cmp("cnt", 64'(bus.retired_cnt), 64'(exp_cnt));
`endif
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick();
    exp_stage  = 6'd1;
    exp_pc     = RPC;
    exp_stat   = 3'd1;
    exp_retire = 1'b0;
    exp_halted = 1'b0;
    exp_cnt    = 32'd0;
    rst = 1'b0;
  endtask

  task automatic halt_to(input logic [2:0] s);
    exp_stage  = 6'd0;
    exp_halted = 1'b1;
    exp_stat   = s;
    exp_retire = 1'b0;
  endtask

  // Called in a FETCH cycle; returns in the next FETCH
  // cycle or in HALTED. lat = cycles consumed.
  task automatic exec(
    input  logic [3:0]  ic,
    input  logic        c,
    input  logic [63:0] vc,
    input  logic [63:0] vm,
    input  logic [63:0] vp,
    input  int          nw,
    input  logic        derr,
    input  logic        ierr,
    output int          lat
  );
    int          st;
    int          f;
    logic [63:0] npc;
    bit          mem;
    st = cyc;
    bus.run = 1'b1;
    bus.icode = ic;
    bus.cnd = c;
    bus.valC = vc;
    bus.valM = vm;
    bus.valP = vp;
    bus.imem_error = ierr;
    bus.dmem_ready = 1'b0;
    bus.dmem_error = 1'b0;
    f = ierr ? 3 : (ic > 4'hB) ? 4 :
        (ic == 4'h0) ? 2 : 0;
    if (f != 0) begin
      tick();
      halt_to(3'(f));
      lat = cyc - st;
      return;
    end
    tick(); exp_stage = 6'd2;
    bus.imem_error = 1'b0;
    tick(); exp_stage = 6'd4;
    tick(); exp_stage = 6'd8;
    mem = ic inside {4, 5, 8, 9, 10, 11};
    if (mem) begin
      for (int k = 0; k < 1000; k++) begin
        if (k == nw) begin
          bus.dmem_ready = 1'b1;
          bus.dmem_error = derr;
          break;
        end
        if (k == MWM - 1) begin
          tick();
          halt_to(3'd3);
          lat = cyc - st;
          return;
        end
        tick(); exp_stage = 6'd8;
      end
      if (derr) begin
        tick();
        halt_to(3'd3);
        lat = cyc - st;
        return;
      end
    end else begin
      bus.dmem_ready = 1'b1;
      bus.dmem_error = 1'b1;
    end
    tick(); exp_stage = 6'd16;
    bus.dmem_ready = 1'b0;
    bus.dmem_error = 1'b0;
    case (ic)
      4'h7:    npc = c ? vc : vp;
      4'h8:    npc = vc;
      4'h9:    npc = vm;
      default: npc = vp;
    endcase
    tick();
    exp_stage  = 6'd32;
    exp_pc     = npc;
    exp_retire = 1'b1;
    exp_cnt    = exp_cnt + 32'd1;
    tick();
    exp_stage  = 6'd1;
    exp_retire = 1'b0;
    lat = cyc - st;
  endtask

  int lat;

  initial begin
    rst = 1'b1;
    bus.run = 1'b0;
    bus.icode = 4'h1;
    bus.cnd = 1'b0;
    bus.valC = '0;
    bus.valM = '0;
    bus.valP = '0;
    bus.imem_error = 1'b0;
    bus.dmem_ready = 1'b0;
    bus.dmem_error = 1'b0;
    do_reset();
    chk_en = 1'b1;
    cmp("rst_stage", 64'(bus.stage), 64'd1);
    cmp("rst_pc", bus.pc, 64'h100);

    exec(4'h1, 0, 0, 0, 64'h2, 0, 0, 0, lat);
    cmp("t1_lat", 64'(lat), 64'd6);
    cmp("t1_pc", bus.pc, 64'h2);

    exec(4'h7, 1, 64'hA, 0, 64'h2, 0, 0, 0, lat);
    cmp("t2_taken", bus.pc, 64'hA);
    exec(4'h7, 0, 64'hA, 0, 64'h2, 0, 0, 0, lat);
    cmp("t2_not", bus.pc, 64'h2);

    exec(4'h8, 0, 64'hA, 0, 64'h9, 0, 0, 0, lat);
    cmp("t3_call", bus.pc, 64'hA);
    exec(4'h9, 0, 0, 64'h20, 64'h1, 3, 0, 0, lat);
    cmp("t3_ret", bus.pc, 64'h20);
    cmp("t3_lat", 64'(lat), 64'd9);

    exec(4'h5, 0, 0, 0,
         64'hFFFF_FFFF_FFFF_FFF0, 14, 0, 0, lat);
    cmp("t5_edge_lat", 64'(lat), 64'd20);
    cmp("t5_edge_pc", bus.pc,
        64'hFFFF_FFFF_FFFF_FFF0);

    exec(4'h0, 0, 0, 0, 64'h77, 0, 0, 0, lat);
    cmp("t4_hlt", 64'(bus.stat), 64'd2);
    cmp("t4_pc", bus.pc, 64'hFFFF_FFFF_FFFF_FFF0);
    bus.icode = 4'h1;
    for (int i = 0; i < 4; i++) tick();
    cmp("t4_absorb", 64'(bus.stage), 64'd0);

    do_reset();
    exec(4'hC, 0, 0, 0, 64'h3, 0, 0, 0, lat);
    cmp("t4_ins", 64'(bus.stat), 64'd4);
    do_reset();
    exec(4'h1, 0, 0, 0, 64'h3, 0, 0, 1, lat);
    cmp("t4_imem", 64'(bus.stat), 64'd3);
    cmp("t4_imem_pc", bus.pc, 64'h100);

    do_reset();
    exec(4'h4, 0, 0, 0, 64'h3, 999, 0, 0, lat);
    cmp("t5_to_lat", 64'(lat), 64'd18);
    cmp("t5_to_stat", 64'(bus.stat), 64'd3);
    for (int i = 0; i < 3; i++) tick();
    do_reset();
    exec(4'hA, 0, 0, 0, 64'h3, 2, 1, 0, lat);
    cmp("t5_derr", 64'(bus.stat), 64'd3);

    do_reset();
    exec(4'h6, 0, 0, 0, 64'h40, 0, 0, 0, lat);
    cmp("t6_pre_pc", bus.pc, 64'h40);
    bus.icode = 4'h4;
    bus.dmem_ready = 1'b0;
    tick(); exp_stage = 6'd2;
    tick(); exp_stage = 6'd4;
    tick(); exp_stage = 6'd8;
    tick(); exp_stage = 6'd8;
    do_reset();
    cmp("t6_stage", 64'(bus.stage), 64'd1);
    cmp("t6_pc", bus.pc, 64'h100);
    bus.run = 1'b0;
    bus.icode = 4'h1;
    for (int i = 0; i < 3; i++) tick();
    cmp("t6_hold", 64'(bus.stage), 64'd1);

    for (int i = 0; i < 3; i++)
      exec(4'h1, 0, 0, 0, 64'(i + 1), 0, 0, 0, lat);
`ifdef RETIRE_CNT_EN
    cmp("t6_cnt", 64'(bus.retired_cnt), 64'd3);
`endif
    cmp("t6_pc3", bus.pc, 64'h3);
    bus.run = 1'b0;
    tick();
    @(negedge clk);
    chk_en = 1'b0;
    $display("[TB] %0d tests run, %0d failed",
             n_tests, n_fail);
    $finish;
  end

endmodule
